pc_unit: RTL

- Parametrised program-counter unit for the single-cycle and pipelined datapaths. Successor to the plain PC register.
- Adds a configurable reset vector and increment, plus a sticky halt state.
- Adds prioritised redirect (branch/jump) and a circular return-address stack (RAS) for call/return prediction.
- Sits between fetch and the hazard/control unit; its output drives the instruction memory address.

---
 rtl/pc_unit.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program-counter unit for the fetch stage. Holds the current PC,
//             advances it by a fixed increment, applies taken branch/jump
//             redirects, and predicts call/return targets with a circular
//             return-address stack (RAS). A sticky HALTED state freezes the
//             unit until reset.
//
//  Ports    :
//    CLK            in   1        rising-edge clock
//    RST            in   1        asynchronous active-high reset
//    adv            in   1        advance enable (0 = stall this cycle)
//    halt           in   1        halt request, sticky once accepted
//    redirect_valid in   1        branch/jump taken this cycle
//    redirect_pc    in   WIDTH    redirect target
//    call           in   1        redirect is a call: push return address
//    ret            in   1        return: next PC from RAS top
//    PC             out  WIDTH    current program counter
//    pc_next        out  WIDTH    value PC takes at the next edge
//    halted         out  1        unit is in HALTED state
//    ras_count      out  CW       number of valid RAS entries
//    ras_underflow  out  1        one-cycle pulse: ret accepted on empty RAS
//
//  Revision : 1.0  initial release
// ============================================================================
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] PC_INIT   = '0,
  parameter logic [WIDTH-1:0] PC_INC    = WIDTH'(4),
  parameter int               RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         adv,
  input  logic                         halt,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_pc,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             PC,
  output logic [WIDTH-1:0]             pc_next,
  output logic                         halted,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_underflow
);

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int PW = $clog2(RAS_DEPTH);   // stack pointer width
  localparam int CW = PW + 1;              // occupancy counter width

  localparam logic [CW-1:0] C_RAS_FULL = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] C_SP_ONE   = PW'(1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic [PW-1:0]    r_sp;        // next free slot; top of stack is r_sp-1
  logic [CW-1:0]    r_count;
  logic             r_underflow;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  // --------------------------------------------------------------------------
  // Per-cycle decode
  // --------------------------------------------------------------------------
  logic             w_running;
  logic             w_accept;     // this edge actually moves the PC
  logic             w_redirect;
  logic             w_push;
  logic             w_ret;
  logic             w_ras_empty;
  logic             w_pop;
  logic             w_underflow;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_ras_top;
  logic [PW-1:0]    w_sp_top;

  always_comb begin
    w_running   = (r_state == ST_RUN);
    // halt wins over everything, then a stall; neither moves the PC.
    w_accept    = w_running && !halt && adv;
    w_redirect  = w_accept && redirect_valid;
    // call only has meaning together with a taken redirect.
    w_push      = w_redirect && call;
    // ret is ignored whenever a redirect is taken in the same cycle.
    w_ret       = w_accept && !redirect_valid && ret;
    w_ras_empty = (r_count == '0);
    w_pop       = w_ret && !w_ras_empty;
    w_underflow = w_ret && w_ras_empty;
  end

  // Sequential successor; wraps modulo 2^WIDTH by construction.
  assign w_pc_inc  = r_pc + PC_INC;

  // The stack is circular: the pointer wraps naturally because RAS_DEPTH
  // is a power of two, so a push when full overwrites the oldest entry.
  assign w_sp_top  = r_sp - C_SP_ONE;
  assign w_ras_top = r_ras[w_sp_top];

  // --------------------------------------------------------------------------
  // Next-PC selection (fully combinational from all inputs)
  // --------------------------------------------------------------------------
  always_comb begin
    pc_next = r_pc;
    if (w_accept) begin
      if (redirect_valid) begin
        pc_next = redirect_pc;
      end else if (w_pop) begin
        pc_next = w_ras_top;
      end else begin
        // plain sequential step, also taken for ret on an empty stack
        pc_next = w_pc_inc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: RUN -> HALTED on any edge with halt=1; only reset leaves.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (halt) begin
            r_state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // PC register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc <= PC_INIT;
    end else begin
      r_pc <= pc_next;
    end
  end

  // --------------------------------------------------------------------------
  // RAS pointer and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + C_SP_ONE;
        // once full, the count saturates while the oldest entry is lost
        if (r_count != C_RAS_FULL) begin
          r_count <= r_count + C_CNT_ONE;
        end
      end else if (w_pop) begin
        r_sp    <= w_sp_top;
        r_count <= r_count - C_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAS storage. Contents are don't-care after reset, so no reset branch;
  // the occupancy counter alone decides what is valid.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras_entry
      always_ff @(posedge CLK) begin
        if (w_push && (r_sp == PW'(gi))) begin
          r_ras[gi] <= w_pc_inc;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Underflow pulse: registered so it appears for exactly the cycle after
  // the edge that accepted the offending ret.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_underflow;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign PC            = r_pc;
  assign halted        = (r_state == ST_HALTED);
  assign ras_count     = r_count;
  assign ras_underflow = r_underflow;

endmodule
`default_nettype wire
